cpu_mem_loader: RTL and testbench

Host-side initiator for the CPU's external memory ports. It receives a byte-stream command protocol on a valid/ready input and turns it into word writes on the instruction-memory and data-memory external ports. It returns data-memory contents as a byte stream on a valid/ready output. It also owns the CPU `enable` line, so programs are loaded, run, halted and dumped without touching the core's pipeline.

---
 rtl/cpu_mem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_mem_loader.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_loader.sv
// Byte-stream command loader for the CPU's external instruction/data memory ports.
// Loads imem/dmem words, dumps dmem words as bytes, and owns the CPU enable line.
module cpu_mem_loader #(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic        err
);
  localparam logic [7:0] OP_LOAD_IMEM = 8'hA1;
  localparam logic [7:0] OP_LOAD_DMEM = 8'hA2;
  localparam logic [7:0] OP_DUMP_DMEM = 8'hA3;
  localparam logic [7:0] OP_RUN       = 8'hA4;
  localparam logic [7:0] OP_HALT      = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_RD_REQ, S_RD_WAIT, S_TX, S_RUN
  } state_t;

  state_t      r_state;
  logic        r_is_dmem;
  logic        r_is_dump;
  logic [2:0]  r_byte_cnt;
  logic [15:0] r_index;
  logic [15:0] r_count;
  logic [63:0] r_buf;
  logic [63:0] r_addr;
  logic [31:0] r_wdata;
  logic [63:0] r_addr_2;
  logic [63:0] r_wdata_2;
  logic        r_wen;
  logic        r_wen_2;
  logic        r_ren_2;
  logic        r_enable;
  logic        r_err;
  logic        r_tx_valid;

  logic        w_rx_hs;
  logic        w_tx_hs;
  logic        w_word_last;
  logic [15:0] w_hdr_count;
  logic [63:0] w_imem_addr;
  logic [63:0] w_dmem_addr;

  // Handshake: a byte moves when valid && ready are both high at a rising edge.
  assign rx_ready    = (r_state == S_IDLE) || (r_state == S_HDR) ||
                       (r_state == S_DATA) || (r_state == S_RUN);
  assign busy        = !((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_rx_hs     = rx_valid && rx_ready;
  assign w_tx_hs     = r_tx_valid && tx_ready;
  assign w_word_last = (r_byte_cnt == (r_is_dmem ? 3'd7 : 3'd3));
  assign w_hdr_count = {rx_data, r_count[7:0]};
  assign w_imem_addr = {{(62-IMEM_AW){1'b0}}, r_index[IMEM_AW-1:0], 2'b00};
  assign w_dmem_addr = {{(61-DMEM_AW){1'b0}}, r_index[DMEM_AW-1:0], 3'b000};

  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_buf[7:0];
  assign addr_ext    = r_addr;
  assign wen_ext     = r_wen;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata;
  assign addr_ext_2  = r_addr_2;
  assign wen_ext_2   = r_wen_2;
  assign ren_ext_2   = r_ren_2;
  assign wdata_ext_2 = r_wdata_2;
  assign enable      = r_enable;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_dmem  <= 1'b0;
      r_is_dump  <= 1'b0;
      r_byte_cnt <= 3'd0;
      r_index    <= 16'd0;
      r_count    <= 16'd0;
      r_buf      <= 64'd0;
      r_addr     <= 64'd0;
      r_wdata    <= 32'd0;
      r_addr_2   <= 64'd0;
      r_wdata_2  <= 64'd0;
      r_wen      <= 1'b0;
      r_wen_2    <= 1'b0;
      r_ren_2    <= 1'b0;
      r_enable   <= 1'b0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
    end else begin
      r_wen   <= 1'b0;
      r_wen_2 <= 1'b0;
      r_ren_2 <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_rx_hs) begin
          r_byte_cnt <= 3'd0;
          case (rx_data)
            OP_LOAD_IMEM: begin r_state <= S_HDR; r_is_dmem <= 1'b0; r_is_dump <= 1'b0; end
            OP_LOAD_DMEM: begin r_state <= S_HDR; r_is_dmem <= 1'b1; r_is_dump <= 1'b0; end
            OP_DUMP_DMEM: begin r_state <= S_HDR; r_is_dmem <= 1'b1; r_is_dump <= 1'b1; end
            OP_RUN:       begin r_state <= S_RUN; r_enable <= 1'b1; end
            default:      r_err <= 1'b1;
          endcase
        end
        S_HDR: if (w_rx_hs) begin
          r_byte_cnt <= r_byte_cnt + 3'd1;
          case (r_byte_cnt[1:0])
            2'd0: r_index[7:0]  <= rx_data;
            2'd1: r_index[15:8] <= rx_data;
            2'd2: r_count[7:0]  <= rx_data;
            default: begin
              r_count[15:8] <= rx_data;
              r_byte_cnt    <= 3'd0;
              if (w_hdr_count == 16'd0) begin
                r_state <= S_IDLE;
              end else if (r_is_dump) begin
                r_state  <= S_RD_REQ;
                r_ren_2  <= 1'b1;
                r_addr_2 <= w_dmem_addr;
              end else begin
                r_state <= S_DATA;
              end
            end
          endcase
        end
        // Bytes shift in from the top, so a finished word is left-aligned in r_buf.
        S_DATA: if (w_rx_hs) begin
          r_buf      <= {rx_data, r_buf[63:8]};
          r_byte_cnt <= r_byte_cnt + 3'd1;
          if (w_word_last) begin
            r_byte_cnt <= 3'd0;
            r_state    <= S_WRITE;
            if (r_is_dmem) begin
              r_wen_2   <= 1'b1;
              r_addr_2  <= w_dmem_addr;
              r_wdata_2 <= {rx_data, r_buf[63:8]};
            end else begin
              r_wen   <= 1'b1;
              r_addr  <= w_imem_addr;
              r_wdata <= {rx_data, r_buf[63:40]};
            end
          end
        end
        S_WRITE: begin
          r_index <= r_index + 16'd1;
          r_count <= r_count - 16'd1;
          r_state <= (r_count == 16'd1) ? S_IDLE : S_DATA;
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_buf      <= rdata_ext_2;
          r_tx_valid <= 1'b1;
          r_index    <= r_index + 16'd1;
          r_count    <= r_count - 16'd1;
          r_state    <= S_TX;
        end
        // tx_data is the low byte of r_buf; shifting only on acceptance keeps it stable.
        S_TX: if (w_tx_hs) begin
          r_buf      <= {8'h00, r_buf[63:8]};
          r_byte_cnt <= r_byte_cnt + 3'd1;
          if (r_byte_cnt == 3'd7) begin
            r_tx_valid <= 1'b0;
            r_byte_cnt <= 3'd0;
            if (r_count != 16'd0) begin
              r_state  <= S_RD_REQ;
              r_ren_2  <= 1'b1;
              r_addr_2 <= w_dmem_addr;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RUN: if (w_rx_hs) begin
          if (rx_data == OP_HALT) begin
            r_enable <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: directed scenarios plus randomized load/dump traffic
// checked against a word-level memory model with an external dmem behind the DUT.
module tb_cpu_mem_loader;
  logic        clk, rst;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic [31:0] wdata_ext;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, err;

  cpu_mem_loader #(.IMEM_AW(9), .DMEM_AW(10)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [127:0] exp_q[$];
  logic [127:0] obs_i_q[$];
  logic [127:0] obs_d_q[$];
  logic [7:0]   exp_b_q[$];
  logic [7:0]   tx_q[$];
  logic [63:0]  dmem [0:1023];
  logic [63:0]  ref_mem [0:1023];
  int           err_cnt = 0;
  int           hold_bad = 0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  int           tx_mode = 0;
  int           gap_max = 0;

  // ---------------- clock / reset / environment ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] = wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  always @(negedge clk) begin
    if (wen_ext)   obs_i_q.push_back({addr_ext, 32'h0, wdata_ext});
    if (wen_ext_2) obs_d_q.push_back({addr_ext_2, wdata_ext_2});
    if (err === 1'b1) err_cnt++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_bad++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rx_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL send_byte_timeout: byte %02h, rx_ready=%0b want 1", b, rx_ready);
    end
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] idx, input logic [15:0] cnt);
    send_byte(op);
    send_byte(idx[7:0]);  send_byte(idx[15:8]);
    send_byte(cnt[7:0]);  send_byte(cnt[15:8]);
  endtask

  task automatic send_word(input logic [63:0] w, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%0b want 0", name, busy);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rx_ready, tx_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, err} !== 9'b100000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %09b want 100000000",
               {rx_ready, tx_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, err});
    end
    n_cmp++;
    if (tx_data !== 8'h00 || addr_ext !== 64'h0 || wdata_ext !== 32'h0 ||
        addr_ext_2 !== 64'h0 || wdata_ext_2 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got tx=%h a=%h w=%h a2=%h w2=%h want all 0",
               tx_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_imem();
    logic [7:0] s[];
    s = '{8'hA1, 8'h00, 8'h00, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h40};
    obs_i_q.delete(); exp_q.delete();
    exp_q.push_back({64'h0, 32'h0, 32'h00A00513});
    exp_q.push_back({64'h4, 32'h0, 32'h06400593});
    foreach (s[i]) send_byte(s[i]);
    send_byte(8'h06);
    @(negedge clk);
    n_cmp++;
    if ({wen_ext, busy} !== 2'b11 || addr_ext !== 64'h4 || wdata_ext !== 32'h06400593) begin
      n_fail++;
      $display("FAIL imem_write_latency: got wen=%0b busy=%0b a=%h w=%h want 1 1 4 06400593",
               wen_ext, busy, addr_ext, wdata_ext);
    end
    @(negedge clk);
    n_cmp++;
    if ({wen_ext, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL imem_busy_drop: got wen=%0b busy=%0b want 0 0", wen_ext, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (obs_i_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL imem_count: got %0d writes want %0d", obs_i_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_i_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL imem_word%0d: got %h want %h", i, obs_i_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_load_dmem();
    obs_i_q.delete(); obs_d_q.delete();
    send_hdr(8'hA2, 16'h0003, 16'h0001);
    send_word(64'h1122334455667788, 8);
    ref_mem[3] = 64'h1122334455667788;
    wait_idle("dmem");
    n_cmp++;
    if (obs_d_q.size() != 1 || obs_i_q.size() != 0) begin
      n_fail++;
      $display("FAIL dmem_count: got d=%0d i=%0d writes want 1 0", obs_d_q.size(), obs_i_q.size());
    end else begin
      n_cmp++;
      if (obs_d_q[0] !== {64'h18, 64'h1122334455667788}) begin
        n_fail++;
        $display("FAIL dmem_word: got %h want %h", obs_d_q[0], {64'h18, 64'h1122334455667788});
      end
    end
  endtask

  task automatic test_dump();
    dmem[3] = 64'h1122334455667788;
    ref_mem[3] = 64'h1122334455667788;
    tx_q.delete(); exp_b_q.delete(); hold_bad = 0;
    for (int i = 0; i < 8; i++) exp_b_q.push_back(ref_mem[3][8*i +: 8]);
    tx_mode = 1;
    send_hdr(8'hA3, 16'h0003, 16'h0001);
    @(negedge clk);
    n_cmp++;
    if ({ren_ext_2, tx_valid} !== 2'b10 || addr_ext_2 !== 64'h18) begin
      n_fail++;
      $display("FAIL dump_rd_req: got ren=%0b txv=%0b a2=%h want 1 0 18", ren_ext_2, tx_valid, addr_ext_2);
    end
    @(negedge clk);
    n_cmp++;
    if ({ren_ext_2, tx_valid, rx_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL dump_rd_wait: got ren=%0b txv=%0b rdy=%0b want 0 0 0", ren_ext_2, tx_valid, rx_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h88 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_first_byte: got txv=%0b d=%h rdy=%0b want 1 88 0", tx_valid, tx_data, rx_ready);
    end
    @(posedge clk); #1;
    wait_idle("dump");
    tx_mode = 0;
    n_cmp++;
    if (tx_q.size() != exp_b_q.size()) begin
      n_fail++;
      $display("FAIL dump_count: got %0d bytes want %0d", tx_q.size(), exp_b_q.size());
    end else begin
      foreach (exp_b_q[i]) begin
        n_cmp++;
        if (tx_q[i] !== exp_b_q[i]) begin
          n_fail++;
          $display("FAIL dump_byte%0d: got %h want %h", i, tx_q[i], exp_b_q[i]);
        end
      end
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_fail++;
      $display("FAIL dump_hold: got %0d unstable stalls want 0", hold_bad);
    end
  endtask

  task automatic test_run_halt();
    int e0;
    e0 = err_cnt;
    send_byte(8'hA4);
    @(negedge clk);
    n_cmp++;
    if ({enable, busy, rx_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL run_enable: got en=%0b busy=%0b rdy=%0b want 1 0 1", enable, busy, rx_ready);
    end
    @(posedge clk); #1;
    send_byte(8'hA1);
    @(negedge clk);
    n_cmp++;
    if ({err, enable} !== 2'b11) begin
      n_fail++;
      $display("FAIL run_bad_op_err: got err=%0b en=%0b want 1 1", err, enable);
    end
    @(negedge clk);
    n_cmp++;
    if ({err, enable} !== 2'b01) begin
      n_fail++;
      $display("FAIL run_err_pulse: got err=%0b en=%0b want 0 1", err, enable);
    end
    @(posedge clk); #1;
    send_byte(8'hA5);
    @(negedge clk);
    n_cmp++;
    if ({enable, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL halt: got en=%0b busy=%0b err=%0b want 0 0 0", enable, busy, err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (err_cnt != e0 + 1) begin
      n_fail++;
      $display("FAIL run_err_count: got %0d want %0d", err_cnt - e0, 1);
    end
  endtask

  task automatic test_zero_count_bad_op();
    int e0;
    e0 = err_cnt;
    obs_i_q.delete(); obs_d_q.delete();
    send_hdr(8'hA1, 16'h0000, 16'h0000);
    @(negedge clk);
    n_cmp++;
    if ({busy, wen_ext, rx_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL zero_count_idle: got busy=%0b wen=%0b rdy=%0b want 0 0 1", busy, wen_ext, rx_ready);
    end
    @(posedge clk); #1;
    send_byte(8'h5A);
    @(negedge clk);
    n_cmp++;
    if ({err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_op_err: got err=%0b busy=%0b want 1 0", err, busy);
    end
    @(posedge clk); #1;
    send_byte(8'hA5);
    @(negedge clk);
    n_cmp++;
    if ({err, enable} !== 2'b10) begin
      n_fail++;
      $display("FAIL halt_in_idle_err: got err=%0b en=%0b want 1 0", err, enable);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if (err_cnt != e0 + 2 || obs_i_q.size() + obs_d_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_count_summary: got errs=%0d writes=%0d want 2 0",
               err_cnt - e0, obs_i_q.size() + obs_d_q.size());
    end
  endtask

  task automatic test_reset_mid();
    obs_i_q.delete(); exp_q.delete();
    send_hdr(8'hA1, 16'h0000, 16'h0001);
    send_byte(8'h13); send_byte(8'h05);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rx_ready, tx_valid, wen_ext, wen_ext_2, ren_ext_2, enable, busy, err} !== 8'b10000000 ||
        addr_ext !== 64'h0 || wdata_ext !== 32'h0 || addr_ext_2 !== 64'h0 || wdata_ext_2 !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got ctl=%08b a=%h w=%h a2=%h w2=%h want 10000000 and zeros",
               {rx_ready, tx_valid, wen_ext, wen_ext_2, ren_ext_2, enable, busy, err},
               addr_ext, wdata_ext, addr_ext_2, wdata_ext_2);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if (obs_i_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_write: got %0d writes want 0", obs_i_q.size());
    end
    send_byte(8'hA4);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({enable, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_in_run: got en=%0b busy=%0b want 0 0", enable, busy);
    end
    @(posedge clk); #1;
    send_hdr(8'hA1, 16'h0005, 16'h0001);
    send_word(64'h00000000EFBEADDE, 4);
    wait_idle("after_reset");
    n_cmp++;
    if (obs_i_q.size() != 1) begin
      n_fail++;
      $display("FAIL after_reset_count: got %0d writes want 1", obs_i_q.size());
    end else begin
      n_cmp++;
      if (obs_i_q[0] !== {64'h14, 32'h0, 32'hEFBEADDE}) begin
        n_fail++;
        $display("FAIL after_reset_word: got %h want %h", obs_i_q[0], {64'h14, 32'h0, 32'hEFBEADDE});
      end
    end
  endtask

  task automatic test_random();
    int unsigned kind, idx, cnt, k, last_d_idx;
    logic [31:0] w32;
    logic [63:0] w64;
    logic [127:0] got_q[$];
    logic [7:0] op;
    last_d_idx = 16'hFFFF;
    gap_max = 2;
    tx_mode = 2;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       idx = 32'hFFFF;
        1:       idx = 32'hFFFE;
        2:       idx = last_d_idx;
        default: idx = $urandom_range(0, 65535);
      endcase
      cnt = $urandom_range(1, 3);
      obs_i_q.delete(); obs_d_q.delete(); tx_q.delete();
      exp_q.delete(); exp_b_q.delete(); hold_bad = 0;
      op = (kind == 0) ? 8'hA1 : (kind == 1) ? 8'hA2 : 8'hA3;
      send_hdr(op, 16'(idx), 16'(cnt));
      for (int i = 0; i < int'(cnt); i++) begin
        k = (idx + i) % 65536;
        if (kind == 0) begin
          w32 = $urandom;
          exp_q.push_back({64'((k % 512) * 4), 32'h0, w32});
          send_word({32'h0, w32}, 4);
        end else if (kind == 1) begin
          w64 = {$urandom, $urandom};
          ref_mem[k % 1024] = w64;
          exp_q.push_back({64'((k % 1024) * 8), w64});
          send_word(w64, 8);
        end else begin
          for (int b = 0; b < 8; b++) exp_b_q.push_back(ref_mem[k % 1024][8*b +: 8]);
        end
      end
      if (kind == 1) last_d_idx = idx;
      wait_idle("random");
      if (kind == 2) begin
        n_cmp++;
        if (tx_q.size() != exp_b_q.size() || hold_bad != 0) begin
          n_fail++;
          $display("FAIL rand%0d_dump: got %0d bytes hold_bad=%0d want %0d 0",
                   it, tx_q.size(), hold_bad, exp_b_q.size());
        end else begin
          foreach (exp_b_q[i]) begin
            n_cmp++;
            if (tx_q[i] !== exp_b_q[i]) begin
              n_fail++;
              $display("FAIL rand%0d_dump_byte%0d: got %h want %h", it, i, tx_q[i], exp_b_q[i]);
            end
          end
        end
      end else begin
        if (kind == 0) got_q = obs_i_q;
        else got_q = obs_d_q;
        n_cmp++;
        if (got_q.size() != exp_q.size() || obs_i_q.size() + obs_d_q.size() != exp_q.size()) begin
          n_fail++;
          $display("FAIL rand%0d_write_count: got i=%0d d=%0d want %0d on kind %0d",
                   it, obs_i_q.size(), obs_d_q.size(), exp_q.size(), kind);
        end else begin
          foreach (exp_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
              n_fail++;
              $display("FAIL rand%0d_word%0d: got %h want %h", it, i, got_q[i], exp_q[i]);
            end
          end
        end
      end
    end
    gap_max = 0;
    tx_mode = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      dmem[i]    = {$urandom, $urandom};
      ref_mem[i] = dmem[i];
    end
    test_reset();
    test_load_imem();
    test_load_dmem();
    test_dump();
    test_run_halt();
    test_zero_count_bad_op();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
